// File: rtl/stopwatch_pkg.sv
// Shared types, 7-segment encoding and digit radix helper for the stopwatch.
`timescale 1ns/1ps
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} sw_state_t;

    // Active-low {dp,g,f,e,d,c,b,a} codes for digits 0..9, dp off
    localparam logic [0:9][7:0] SEG_LUT = {
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Segment pattern for one BCD digit; anything above 9 blanks the digit
    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] code;
        code = SEG_BLANK;
        if (d <= 4'd9) code = SEG_LUT[d];
        return code;
    endfunction

    // Two low digits and every even digit are decimal; odd digits above are base 6
    function automatic int unsigned digit_radix(input int unsigned i);
        return ((i < 2) || ((i % 2) == 0)) ? 10 : 6;
    endfunction

endpackage

// File: rtl/sw_digit_cnt.sv
// One BCD digit of the stopwatch count with configurable radix and ripple carry.
`timescale 1ns/1ps
module sw_digit_cnt #(
    parameter int unsigned RADIX = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] val,
    output logic       carry_c
);

    // Carry out when this digit is incremented at its top value
    assign carry_c = inc && (val == 4'(RADIX - 1));

    // Digit register; clear overrides an increment in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val <= 4'd0;
        end else if (clr) begin
            val <= 4'd0;
        end else if (inc) begin
            val <= carry_c ? 4'd0 : val + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Multiplexed-display stopwatch: run/stop/clear control, BCD count chain,
// optional lap display latch (STOPWATCH_LAP_EN) and digit scanner.
`timescale 1ns/1ps
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 100,
    parameter int unsigned SCAN_HZ = 500,
    parameter int unsigned DIGITS  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_stop,
    input  logic              clear,
    input  logic              lap,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] dig_sel,
    output logic              running,
    output logic              overflow
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W    = $clog2(DIGITS);

    sw_state_t                state_q, state_d;
    logic                     running_d;
    logic                     div_rst_c;
    logic                     counting_c;
    logic                     tick_c;
    logic [TICK_W-1:0]        tdiv_q;
    logic [DIGITS:0]          inc_c;
    logic [DIGITS-1:0][3:0]   cnt;
    logic [DIGITS-1:0][3:0]   disp;
    logic [SCAN_W-1:0]        sdiv_q;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [7:0]               seg_d;

    // State and running flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            running <= running_d;
        end
    end

    // Next state with clear > start_stop > lap priority
    always_comb begin
        state_d   = state_q;
        running_d = 1'b0;
        div_rst_c = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else if (start_stop) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = STOP;
                STOP:    state_d = RUN;
                LAP:     state_d = STOP;
                default: state_d = IDLE;
            endcase
        end
`ifdef STOPWATCH_LAP_EN
        else if (lap) begin
            if (state_q == RUN) state_d = LAP;
            else if (state_q == LAP) state_d = RUN;
        end
`endif
        running_d = (state_d == RUN) || (state_d == LAP);
        div_rst_c = (state_d == RUN) && ((state_q == IDLE) || (state_q == STOP));
    end

`ifndef STOPWATCH_LAP_EN
    wire lap_unused = lap;
`endif

    assign counting_c = (state_q == RUN) || (state_q == LAP);
    assign tick_c     = counting_c && (tdiv_q == TICK_W'(TICK_DIV - 1));

    // Tick divider: restarts on entry to RUN, holds while stopped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdiv_q <= '0;
        end else if (clear || div_rst_c) begin
            tdiv_q <= '0;
        end else if (counting_c) begin
            tdiv_q <= tick_c ? '0 : tdiv_q + TICK_W'(1);
        end
    end

    assign inc_c[0] = tick_c;

    // Ripple chain of BCD digits, d0 least significant
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        sw_digit_cnt #(
            .RADIX(digit_radix(gi))
        ) u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clear),
            .inc    (inc_c[gi]),
            .val    (cnt[gi]),
            .carry_c(inc_c[gi+1])
        );
    end

    // Sticky flag set by a carry out of the top digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (inc_c[DIGITS]) begin
            overflow <= 1'b1;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [DIGITS-1:0][3:0] disp_q;

    // Display latch tracks the live count except while a lap is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
        end else if (clear) begin
            disp_q <= '0;
        end else if (state_q != LAP) begin
            disp_q <= cnt;
        end
    end

    assign disp = disp_q;
`else
    assign disp = cnt;
`endif

    // Next scan index and segment pattern, dp lit on even digits from 2 up
    always_comb begin
        idx_d = idx_q;
        if (sdiv_q == SCAN_W'(SCAN_DIV - 1)) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        seg_d = seg_code(disp[idx_d]);
        if (!idx_d[0] && (idx_d != '0)) seg_d[7] = 1'b0;
    end

    // Scanner registers driving the display pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdiv_q  <= '0;
            idx_q   <= '0;
            dig_sel <= ~DIGITS'(1);
            seg     <= 8'hC0;
        end else begin
            sdiv_q  <= (sdiv_q == SCAN_W'(SCAN_DIV - 1)) ? '0 : sdiv_q + SCAN_W'(1);
            idx_q   <= idx_d;
            dig_sel <= ~(DIGITS'(1) << idx_d);
            seg     <= seg_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a 6-digit instance at 10 cycles/tick and
// a 4-digit instance ticking every cycle to reach full-scale wrap quickly.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
    logic [7:0] seg;
    logic [5:0] dig_sel;
    logic       running, overflow;
    logic       ss2 = 1'b0, clr2 = 1'b0;
    logic [7:0] seg2;
    logic [3:0] dsel2;
    logic       run2, ovf2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(500), .DIGITS(6)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear), .lap(lap),
        .seg(seg), .dig_sel(dig_sel), .running(running), .overflow(overflow)
    );

    stopwatch_ctrl #(.CLK_HZ(100), .TICK_HZ(100), .SCAN_HZ(50), .DIGITS(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_stop(ss2), .clear(clr2), .lap(1'b0),
        .seg(seg2), .dig_sel(dsel2), .running(run2), .overflow(ovf2)
    );

    function automatic logic [3:0] dec7(input logic [6:0] s);
        case (s)
            7'h40: return 4'd0;
            7'h79: return 4'd1;
            7'h24: return 4'd2;
            7'h30: return 4'd3;
            7'h19: return 4'd4;
            7'h12: return 4'd5;
            7'h02: return 4'd6;
            7'h78: return 4'd7;
            7'h00: return 4'd8;
            7'h10: return 4'd9;
            default: return 4'hE;
        endcase
    endfunction

    // Called at a negedge; pulse is sampled on the following posedge
    task automatic pulse(input int which);
        case (which)
            0: start_stop = 1'b1;
            1: clear = 1'b1;
            2: lap = 1'b1;
            3: ss2 = 1'b1;
            default: clr2 = 1'b1;
        endcase
        @(negedge clk);
        start_stop = 1'b0; clear = 1'b0; lap = 1'b0; ss2 = 1'b0; clr2 = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reconstruct the shown value by watching one full scan rotation
    task automatic read_display(input bit which, output logic [23:0] val);
        int nd;
        logic [5:0] seen;
        logic [7:0] s;
        logic [5:0] d;
        logic [5:0] onehot;
        nd = which ? 4 : 6;
        val = '0;
        seen = '0;
        repeat (3) @(negedge clk);
        for (int c = 0; c < 2 * nd; c++) begin
            @(negedge clk);
            s = which ? seg2 : seg;
            d = which ? {2'b11, dsel2} : dig_sel;
            for (int i = 0; i < nd; i++) begin
                onehot = 6'b1 << i;
                if (d == ~onehot) begin
                    val[i*4 +: 4] = dec7(s[6:0]);
                    seen[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < nd; i++) if (!seen[i]) val = 24'hEEEEEE;
    endtask

    task automatic test_reset();
        logic [5:0] exp_sel;
        logic [5:0] onehot;
        logic [7:0] exp_seg;
        int idx;
        wait_cyc(2);
        n_checks++; if (dig_sel !== 6'b111110) $display("FAIL reset_dig_sel got %b want 111110", dig_sel); else n_pass++;
        n_checks++; if (seg !== 8'hC0) $display("FAIL reset_seg got %h want c0", seg); else n_pass++;
        n_checks++; if (running !== 1'b0 || overflow !== 1'b0) $display("FAIL reset_flags got %b%b want 00", running, overflow); else n_pass++;
        n_checks++; if (dsel2 !== 4'b1110) $display("FAIL reset_dsel2 got %b want 1110", dsel2); else n_pass++;
        rst_n = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            idx = (k / 2) % 6;
            onehot = 6'b1 << idx;
            exp_sel = ~onehot;
            exp_seg = (idx == 2 || idx == 4) ? 8'h40 : 8'hC0;
            n_checks++; if (dig_sel !== exp_sel || seg !== exp_seg)
                $display("FAIL scan_walk k=%0d got sel=%b seg=%h want sel=%b seg=%h", k, dig_sel, seg, exp_sel, exp_seg);
            else n_pass++;
        end
        n_checks++; if (running !== 1'b0) $display("FAIL idle_running got %b want 0", running); else n_pass++;
    endtask

    task automatic test_first_tick();
        logic [23:0] v;
        pulse(0);
        n_checks++; if (running !== 1'b1) $display("FAIL start_running got %b want 1", running); else n_pass++;
        wait_cyc(8); pulse(0);
        n_checks++; if (running !== 1'b0) $display("FAIL stop_running got %b want 0", running); else n_pass++;
        read_display(1'b0, v);
        n_checks++; if (v !== 24'h000000) $display("FAIL tick_9cyc got %h want 000000", v); else n_pass++;
        pulse(1);
        pulse(0); wait_cyc(9); pulse(0);
        read_display(1'b0, v);
        n_checks++; if (v !== 24'h000001) $display("FAIL tick_10cyc got %h want 000001", v); else n_pass++;
    endtask

    task automatic test_run_and_stop();
        logic [23:0] v;
        pulse(1);
        pulse(0); wait_cyc(999); pulse(0);
        read_display(1'b0, v);
        n_checks++; if (v !== 24'h000100) $display("FAIL run_1000 got %h want 000100", v); else n_pass++;
        wait_cyc(200);
        read_display(1'b0, v);
        n_checks++; if (v !== 24'h000100) $display("FAIL stop_hold got %h want 000100", v); else n_pass++;
        pulse(0); wait_cyc(8); pulse(0);
        read_display(1'b0, v);
        n_checks++; if (v !== 24'h000100) $display("FAIL resume_9a got %h want 000100", v); else n_pass++;
        pulse(0); wait_cyc(8); pulse(0);
        read_display(1'b0, v);
        n_checks++; if (v !== 24'h000100) $display("FAIL resume_9b got %h want 000100", v); else n_pass++;
        pulse(0); wait_cyc(9); pulse(0);
        read_display(1'b0, v);
        n_checks++; if (v !== 24'h000101) $display("FAIL resume_10 got %h want 000101", v); else n_pass++;
    endtask

    task automatic test_lap();
        logic [23:0] v;
        pulse(1);
        pulse(0); wait_cyc(504); pulse(2);
`ifdef STOPWATCH_LAP_EN
        n_checks++; if (running !== 1'b1) $display("FAIL lap_running got %b want 1", running); else n_pass++;
        wait_cyc(285);
        read_display(1'b0, v);
        n_checks++; if (v !== 24'h000050) $display("FAIL lap_hold got %h want 000050", v); else n_pass++;
        pulse(2); pulse(0);
        read_display(1'b0, v);
        n_checks++; if (v !== 24'h000080) $display("FAIL lap_release got %h want 000080", v); else n_pass++;
`else
        wait_cyc(5); pulse(0);
        read_display(1'b0, v);
        n_checks++; if (v !== 24'h000051) $display("FAIL lap_ignored got %h want 000051", v); else n_pass++;
`endif
        n_checks++; if (running !== 1'b0) $display("FAIL lap_stop_running got %b want 0", running); else n_pass++;
    endtask

    task automatic test_coincide();
        logic [23:0] v;
        pulse(1);
        pulse(0); wait_cyc(30);
        clear = 1'b1; start_stop = 1'b1; lap = 1'b1;
        @(negedge clk);
        clear = 1'b0; start_stop = 1'b0; lap = 1'b0;
        n_checks++; if (running !== 1'b0) $display("FAIL coincide_running got %b want 0", running); else n_pass++;
        read_display(1'b0, v);
        n_checks++; if (v !== 24'h000000) $display("FAIL coincide_count got %h want 000000", v); else n_pass++;
        pulse(0); wait_cyc(9); pulse(0);
        read_display(1'b0, v);
        n_checks++; if (v !== 24'h000001) $display("FAIL coincide_restart got %h want 000001", v); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [23:0] v;
        pulse(3); wait_cyc(5998); pulse(3);
        read_display(1'b1, v);
        n_checks++; if (v !== 24'h005999) $display("FAIL full_scale got %h want 005999", v); else n_pass++;
        n_checks++; if (ovf2 !== 1'b0) $display("FAIL ovf_before got %b want 0", ovf2); else n_pass++;
        pulse(3); pulse(3);
        n_checks++; if (ovf2 !== 1'b1) $display("FAIL ovf_set got %b want 1", ovf2); else n_pass++;
        read_display(1'b1, v);
        n_checks++; if (v !== 24'h000000) $display("FAIL wrap_count got %h want 000000", v); else n_pass++;
        pulse(3); wait_cyc(1); pulse(3);
        read_display(1'b1, v);
        n_checks++; if (v !== 24'h000002 || ovf2 !== 1'b1) $display("FAIL after_wrap got %h ovf=%b want 000002 ovf=1", v, ovf2); else n_pass++;
        pulse(4);
        n_checks++; if (ovf2 !== 1'b0 || run2 !== 1'b0) $display("FAIL clear_ovf got ovf=%b run=%b want 0 0", ovf2, run2); else n_pass++;
        read_display(1'b1, v);
        n_checks++; if (v !== 24'h000000) $display("FAIL clear_count got %h want 000000", v); else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [23:0] v;
        pulse(1);
        pulse(0); wait_cyc(25);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (running !== 1'b0 || overflow !== 1'b0) $display("FAIL async_flags got %b%b want 00", running, overflow); else n_pass++;
        n_checks++; if (dig_sel !== 6'b111110 || seg !== 8'hC0) $display("FAIL async_disp got sel=%b seg=%h want 111110 c0", dig_sel, seg); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        read_display(1'b0, v);
        n_checks++; if (v !== 24'h000000 || running !== 1'b0) $display("FAIL async_count got %h run=%b want 000000 0", v, running); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_run_and_stop();
        test_lap();
        test_coincide();
        test_overflow();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Parametrised multiplexed-display stopwatch. It replaces the fixed four-digit, one-second design with a configurable clock rate, tick rate, digit count and scan rate. It adds start/stop, clear and lap control, and a sticky overflow flag. It sits between the debounced front-panel buttons and the common-anode 7-segment module, and drives segments and digit selects directly.

## Interface
Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 100, count rate of the least-significant digit (100 gives centiseconds).
- SCAN_HZ, 500, per-digit refresh rate; each digit is held for CLK_HZ/SCAN_HZ cycles.
- DIGITS, 6, number of display digits; even, range 2..8.

Ports:
- clk  in  1  system clock, CLK_HZ.
- rst_n  in  1  asynchronous, active-low reset.
- start_stop  in  1  one-cycle pulse, already debounced; toggles run/stop.
- clear  in  1  one-cycle pulse; zeroes the count.
- lap  in  1  one-cycle pulse; freezes or releases the displayed value.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- dig_sel  out  DIGITS  one-hot active-low digit enable; bit 0 is the rightmost digit.
- running  out  1  high in RUN and LAP.
- overflow  out  1  sticky; set when the count wraps.

## Operation
- Count is DIGITS BCD digits, d0 least significant. Radices:
  - d0, d1: 10 (0..99 ticks).
  - Every higher even digit: 10.
  - Every higher odd digit: 6, giving mm:ss:cc at DIGITS=6.
- A tick carries through the digit chain like a ripple counter, all in the same cycle.
- Full-scale wrap (e.g. 59:59:99 to 00:00:00) sets overflow. Counting continues after the wrap.
- State machine:
  - IDLE: count zero, stopped.
  - RUN: counting.
  - STOP: frozen.
  - LAP: counting, display latch frozen.
- Transitions:
  - IDLE --start_stop--> RUN.
  - RUN --start_stop--> STOP.
  - STOP --start_stop--> RUN.
  - RUN --lap--> LAP.
  - LAP --lap--> RUN, display resyncs.
  - LAP --start_stop--> STOP, display shows the live count.
  - Any state --clear--> IDLE; clears the count, the display latch and overflow.
- Priority when pulses coincide: clear > start_stop > lap.
- lap is ignored in IDLE and STOP.
- Display latch follows the live count every cycle except in LAP.
- Scanner:
  - Free-running digit index cycles 0..DIGITS-1.
  - seg shows the latched digit for the current index.
  - dp is lit (0) on every even digit index ≥2, as the separator.
  - Digit codes 0..9 only. The LUT default for other codes is all segments off (8'hFF).

## Timing
- Tick divider counts 0..CLK_HZ/TICK_HZ-1. It resets to 0 on every entry to RUN from IDLE or STOP, so the first increment lands exactly CLK_HZ/TICK_HZ cycles after the start_stop pulse.
- Divider holds in STOP and IDLE. It keeps running in LAP.
- Control response:
  - running changes the cycle after the pulse.
  - Count registers update on the divider terminal cycle; seg/dig_sel reflect the new value by the next scan of that digit.
- All outputs are registered.
- Reset values:
  - Count 0, state IDLE, running 0, overflow 0.
  - Scan index 0, so dig_sel = ~1.
  - seg = code for 0 with dp off (8'hC0).
- rst_n assertion mid-count clears all state immediately, asynchronously. Deassertion is synchronised by the system reset bridge upstream.

## Configuration
- STOPWATCH_LAP_EN defined: lap input and the LAP state are implemented as above.
- STOPWATCH_LAP_EN undefined:
  - lap port is still present but ignored.
  - No LAP state and no display latch; the display always shows the live count.
  - All other behaviour is identical.

## Structure
- Package stopwatch_pkg holds:
  - state enum sw_state_t {IDLE, RUN, STOP, LAP}.
  - 7-seg active-low LUT constant (0..9, default 8'hFF).
  - Function digit_radix(i), returning 10 or 6.
- One sub-module, sw_digit_cnt: single BCD digit with radix parameter, inc input, clear input, carry output. It is instantiated DIGITS times in a generate chain.
- Dividers, FSM, latch and scanner stay in stopwatch_ctrl.

## Test plan
Bench uses CLK_HZ=1000, TICK_HZ=100 (10 cycles/tick), SCAN_HZ=500 (2 cycles/digit), DIGITS=6.
- Reset, then idle 50 cycles -> dig_sel walks ~000001..~100000 every 2 cycles; seg=8'hC0 on digits 0,1 and dp lit on digits 2,4; running=0.
- start_stop pulse, run 1000 cycles -> running=1 the next cycle; count 00:01:00 (100 ticks); first increment exactly 10 cycles after the pulse.
- start_stop, wait 200 cycles, start_stop -> count frozen during the stop; resumes with a full 10-cycle first tick.
- With LAP_EN: lap at 00:00:50, run 300 cycles -> display holds 00:00:50; second lap -> display shows 00:00:80.
- Preload near full scale by running to 59:59:99, then one tick -> count 00:00:00 and overflow=1; clear -> overflow=0, IDLE.
- clear, start_stop and lap in the same cycle during RUN -> IDLE, count 0, running=0.
